// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing defaults and types for the timing generator and its consumers.
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_sync_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel-drawing stage.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       hs_d;
  logic       vs_d;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, frame_count);
endinterface

// File: rtl/vga_sync_delay.sv
// Resettable DEPTH-stage shift register used to line sync (or blank) up with a pipelined RGB path.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, rst};
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= {DEPTH{RST_VAL}};
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counter: registered coordinates, syncs, blank and frame markers, all in phase,
// plus sync copies delayed to match the downstream drawing pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIPE_DELAY = 2
) (
  input  logic         vga_clk,
  input  logic         reset,
  vga_timing_if.master vga
);
  localparam int     HT     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     VT     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int     HS_BEG = H_VISIBLE + H_FRONT;
  localparam int     HS_END = HS_BEG + H_SYNC;
  localparam int     VS_BEG = V_VISIBLE + V_FRONT;
  localparam int     VS_END = VS_BEG + V_SYNC;
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);

  if (HT > 1024 || VT > 1024) begin : g_bad_total
    $error("vga_timing_gen: horizontal and vertical totals must not exceed 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
  end

  coord_t     hc, vc, hc_n, vc_n;
  vga_sync_t  sync, sync_n;
  logic       fs;
  logic [7:0] fc;
  logic [1:0] sync_d;

  // Decode from the next counter values so registered syncs land on the same edge as DrawX/DrawY.
  always_comb begin
    hc_n = hc + coord_t'(1);
    vc_n = vc;
    if (hc == H_LAST) begin
      hc_n = '0;
      vc_n = (vc == V_LAST) ? '0 : vc + coord_t'(1);
    end
    sync_n.hs    = !(int'(hc_n) >= HS_BEG && int'(hc_n) < HS_END);
    sync_n.vs    = !(int'(vc_n) >= VS_BEG && int'(vc_n) < VS_END);
    sync_n.blank = (int'(hc_n) < H_VISIBLE) && (int'(vc_n) < V_VISIBLE);
  end

  // Reset parks on the last pixel so the first free-running edge starts frame 1 at (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc   <= H_LAST;
      vc   <= V_LAST;
      sync <= '{hs: 1'b1, vs: 1'b1, blank: 1'b0};
      fs   <= 1'b0;
      fc   <= '0;
    end else begin
      hc   <= hc_n;
      vc   <= vc_n;
      sync <= sync_n;
      fs   <= (hc_n == '0) && (vc_n == '0);
      if ((hc_n == '0) && (vc_n == '0)) fc <= fc + 8'd1;
    end
  end

  vga_sync_delay #(
    .DEPTH  (PIPE_DELAY),
    .WIDTH  (2),
    .RST_VAL(2'b11)
  ) u_sync_dly (
    .clk(vga_clk),
    .rst(reset),
    .d  ({sync.hs, sync.vs}),
    .q  (sync_d)
  );

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = sync.blank;
  assign vga.hs          = sync.hs;
  assign vga.vs          = sync.vs;
  assign vga.hs_d        = sync_d[1];
  assign vga.vs_d        = sync_d[0];
  assign vga.frame_start = fs;
  assign vga.frame_count = fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size 640x480 instance plus two shrunken-raster instances (delay 3 and 0) checked
// against a linear pixel-index reference model.
module tb_vga_timing_gen;
  typedef struct packed {
    int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb; int pd;
  } tcfg_t;

  localparam tcfg_t CA = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pd:2};
  localparam tcfg_t CS = '{hv:5, hf:1, hs:2, hb:2, vv:4, vf:1, vs:2, vb:1, pd:3};
  localparam tcfg_t CZ = '{hv:5, hf:1, hs:2, hb:2, vv:4, vf:1, vs:2, vb:1, pd:0};
  localparam int A_TOT = 800 * 525;
  localparam int S_HT  = 10;
  localparam int S_TOT = 10 * 8;

  logic clk, rst_a, rst_b;
  int   checks, errors, cyc;

  vga_timing_if ifa ();
  vga_timing_if ifs ();
  vga_timing_if ifz ();

  vga_timing_gen #(.H_VISIBLE(CA.hv), .H_FRONT(CA.hf), .H_SYNC(CA.hs), .H_BACK(CA.hb),
                   .V_VISIBLE(CA.vv), .V_FRONT(CA.vf), .V_SYNC(CA.vs), .V_BACK(CA.vb),
                   .PIPE_DELAY(CA.pd)) dut_a (.vga_clk(clk), .reset(rst_a), .vga(ifa));
  vga_timing_gen #(.H_VISIBLE(CS.hv), .H_FRONT(CS.hf), .H_SYNC(CS.hs), .H_BACK(CS.hb),
                   .V_VISIBLE(CS.vv), .V_FRONT(CS.vf), .V_SYNC(CS.vs), .V_BACK(CS.vb),
                   .PIPE_DELAY(CS.pd)) dut_s (.vga_clk(clk), .reset(rst_b), .vga(ifs));
  vga_timing_gen #(.H_VISIBLE(CZ.hv), .H_FRONT(CZ.hf), .H_SYNC(CZ.hs), .H_BACK(CZ.hb),
                   .V_VISIBLE(CZ.vv), .V_FRONT(CZ.vf), .V_SYNC(CZ.vs), .V_BACK(CZ.vb),
                   .PIPE_DELAY(CZ.pd)) dut_z (.vga_clk(clk), .reset(rst_b), .vga(ifz));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ht_of(tcfg_t c);
    return c.hv + c.hf + c.hs + c.hb;
  endfunction
  function automatic logic hs_at(tcfg_t c, int idx);
    int x = idx % ht_of(c);
    return !(x >= c.hv + c.hf && x < c.hv + c.hf + c.hs);
  endfunction
  function automatic logic vs_at(tcfg_t c, int idx);
    int y = idx / ht_of(c);
    return !(y >= c.vv + c.vf && y < c.vv + c.vf + c.vs);
  endfunction
  function automatic logic [33:0] exp_vec(tcfg_t c, int idx, int fc, logic [7:0] hh, logic [7:0] vh);
    int   x  = idx % ht_of(c);
    int   y  = idx / ht_of(c);
    logic bl = (x < c.hv) && (y < c.vv);
    return {10'(x), 10'(y), bl, hs_at(c, idx), vs_at(c, idx), hh[c.pd], vh[c.pd], idx == 0, 8'(fc)};
  endfunction

  // Reference: position is a linear pixel index; sync history bit k = value k cycles ago.
  int a_idx, a_fc, s_idx, s_fc;
  logic [7:0] a_hh, a_vh, s_hh, s_vh;
  always @(posedge clk) begin
    if (rst_a) begin
      a_idx <= A_TOT - 1; a_fc <= 0; a_hh <= '1; a_vh <= '1;
    end else begin
      a_idx <= (a_idx + 1) % A_TOT;
      if ((a_idx + 1) % A_TOT == 0) a_fc <= (a_fc + 1) % 256;
      a_hh <= {a_hh[6:0], hs_at(CA, (a_idx + 1) % A_TOT)};
      a_vh <= {a_vh[6:0], vs_at(CA, (a_idx + 1) % A_TOT)};
    end
  end
  always @(posedge clk) begin
    if (rst_b) begin
      s_idx <= S_TOT - 1; s_fc <= 0; s_hh <= '1; s_vh <= '1;
    end else begin
      s_idx <= (s_idx + 1) % S_TOT;
      if ((s_idx + 1) % S_TOT == 0) s_fc <= (s_fc + 1) % 256;
      s_hh <= {s_hh[6:0], hs_at(CS, (s_idx + 1) % S_TOT)};
      s_vh <= {s_vh[6:0], vs_at(CS, (s_idx + 1) % S_TOT)};
    end
  end

  logic [33:0] exp_a, exp_s, exp_z, obs_a, obs_s, obs_z;
  always_comb exp_a = exp_vec(CA, a_idx, a_fc, a_hh, a_vh);
  always_comb exp_s = exp_vec(CS, s_idx, s_fc, s_hh, s_vh);
  always_comb exp_z = exp_vec(CZ, s_idx, s_fc, s_hh, s_vh);
  assign obs_a = {ifa.DrawX, ifa.DrawY, ifa.blank, ifa.hs, ifa.vs, ifa.hs_d, ifa.vs_d, ifa.frame_start, ifa.frame_count};
  assign obs_s = {ifs.DrawX, ifs.DrawY, ifs.blank, ifs.hs, ifs.vs, ifs.hs_d, ifs.vs_d, ifs.frame_start, ifs.frame_count};
  assign obs_z = {ifz.DrawX, ifz.DrawY, ifz.blank, ifz.hs, ifz.vs, ifz.hs_d, ifz.vs_d, ifz.frame_start, ifz.frame_count};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) step();
    checks++; if (ifa.DrawX !== 10'd799) begin errors++; $display("FAIL reset_drawx got=%0d exp=799", ifa.DrawX); end
    checks++; if (ifa.DrawY !== 10'd524) begin errors++; $display("FAIL reset_drawy got=%0d exp=524", ifa.DrawY); end
    checks++;
    if ({ifa.blank, ifa.hs, ifa.vs, ifa.hs_d, ifa.vs_d, ifa.frame_start} !== 6'b011110) begin
      errors++; $display("FAIL reset_flags got=%b exp=011110", {ifa.blank, ifa.hs, ifa.vs, ifa.hs_d, ifa.vs_d, ifa.frame_start});
    end
    checks++; if (ifa.frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc got=%0d exp=0", ifa.frame_count); end
    checks++; if (obs_s !== {10'd9, 10'd7, 6'b011110, 8'd0}) begin errors++; $display("FAIL reset_small got=%h", obs_s); end
    rst_a = 1'b0; rst_b = 1'b0;
    step();
    checks++; if ({ifa.DrawX, ifa.DrawY} !== 20'd0) begin errors++; $display("FAIL release_xy got=%0d,%0d exp=0,0", ifa.DrawX, ifa.DrawY); end
    checks++; if ({ifa.blank, ifa.frame_start} !== 2'b11) begin errors++; $display("FAIL release_flags got=%b exp=11", {ifa.blank, ifa.frame_start}); end
    checks++; if (ifa.frame_count !== 8'd1) begin errors++; $display("FAIL release_fc got=%0d exp=1", ifa.frame_count); end
    step();
    checks++; if (ifa.frame_start !== 1'b0 || ifa.DrawX !== 10'd1) begin errors++; $display("FAIL fs_one_cycle fs=%b x=%0d exp fs=0 x=1", ifa.frame_start, ifa.DrawX); end
  endtask

  task automatic test_line();
    int guard, hs_lo, bl, hs_first, hsd_fall, row;
    logic prev_hsd;
    guard = 0;
    while (ifa.DrawX !== 10'd799 && guard < 2000) begin step(); guard++; end
    checks++; if (guard >= 2000) begin errors++; $display("FAIL line_align timeout x=%0d", ifa.DrawX); end
    hs_lo = 0; bl = 0; hs_first = -1; hsd_fall = -1; prev_hsd = ifa.hs_d;
    for (int i = 0; i < 800; i++) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL line_model cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
      if (!ifa.hs) begin hs_lo++; if (hs_first < 0) hs_first = ifa.DrawX; end
      if (ifa.blank) bl++;
      if (prev_hsd && !ifa.hs_d && hsd_fall < 0) hsd_fall = ifa.DrawX;
      prev_hsd = ifa.hs_d;
    end
    checks++; if (hs_lo != 96) begin errors++; $display("FAIL hs_width got=%0d exp=96", hs_lo); end
    checks++; if (hs_first != 656) begin errors++; $display("FAIL hs_start got=%0d exp=656", hs_first); end
    checks++; if (bl != 640) begin errors++; $display("FAIL blank_width got=%0d exp=640", bl); end
    checks++; if (hsd_fall != 658) begin errors++; $display("FAIL hs_d_fall got=%0d exp=658", hsd_fall); end
    row = ifa.DrawY;
    step();
    checks++; if (ifa.DrawX !== 10'd0 || int'(ifa.DrawY) != row + 1) begin
      errors++; $display("FAIL line_wrap got=%0d,%0d exp=0,%0d", ifa.DrawX, ifa.DrawY, row + 1);
    end
  endtask

  task automatic test_frame();
    int vs_lo, vs_bad, blank_bad, fs_at, fc_at, vs_fall, vsd_fall;
    logic prev_vs, prev_vsd;
    rst_b = 1'b1; step(); rst_b = 1'b0; step();
    checks++; if (ifs.frame_start !== 1'b1 || ifs.frame_count !== 8'd1) begin errors++; $display("FAIL frame_first fs=%b fc=%0d", ifs.frame_start, ifs.frame_count); end
    vs_lo = 0; vs_bad = 0; blank_bad = 0; fs_at = -1; fc_at = -1; vs_fall = -1; vsd_fall = -1;
    prev_vs = ifs.vs; prev_vsd = ifs.vs_d;
    for (int i = 1; i <= S_TOT; i++) begin
      step();
      checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL frame_model_s i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      checks++; if (obs_z !== exp_z) begin errors++; $display("FAIL frame_model_z i=%0d got=%h exp=%h", i, obs_z, exp_z); end
      checks++; if ({ifz.hs_d, ifz.vs_d} !== {ifz.hs, ifz.vs}) begin errors++; $display("FAIL zero_delay i=%0d got=%b exp=%b", i, {ifz.hs_d, ifz.vs_d}, {ifz.hs, ifz.vs}); end
      if (!ifs.vs) vs_lo++;
      if (ifs.vs !== prev_vs && ifs.DrawX !== 10'd0) vs_bad++;
      if (ifs.DrawY >= 10'd4 && ifs.blank) blank_bad++;
      if (ifs.frame_start && fs_at < 0) begin fs_at = i; fc_at = ifs.frame_count; end
      if (prev_vs && !ifs.vs && vs_fall < 0) vs_fall = i;
      if (prev_vsd && !ifs.vs_d && vsd_fall < 0) vsd_fall = i;
      prev_vs = ifs.vs; prev_vsd = ifs.vs_d;
    end
    checks++; if (vs_lo != 2 * S_HT) begin errors++; $display("FAIL vs_width got=%0d exp=%0d", vs_lo, 2 * S_HT); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL vs_midline got=%0d exp=0", vs_bad); end
    checks++; if (blank_bad != 0) begin errors++; $display("FAIL vblank got=%0d exp=0", blank_bad); end
    checks++; if (vs_fall != 5 * S_HT) begin errors++; $display("FAIL vs_start got=%0d exp=%0d", vs_fall, 5 * S_HT); end
    checks++; if (vsd_fall != vs_fall + 3) begin errors++; $display("FAIL vs_d_lag got=%0d exp=%0d", vsd_fall, vs_fall + 3); end
    checks++; if (fs_at != S_TOT || fc_at != 2) begin errors++; $display("FAIL frame_period at=%0d fc=%0d exp at=%0d fc=2", fs_at, fc_at, S_TOT); end
  endtask

  task automatic test_reset_mid();
    int guard, n;
    guard = 0;
    while (ifa.DrawX !== 10'd300 && guard < 2000) begin step(); guard++; end
    checks++; if (guard >= 2000) begin errors++; $display("FAIL mid_align timeout x=%0d", ifa.DrawX); end
    rst_a = 1'b1; step(); rst_a = 1'b0;
    checks++; if (obs_a !== {10'd799, 10'd524, 6'b011110, 8'd0}) begin errors++; $display("FAIL mid_reset_a got=%h", obs_a); end
    step();
    checks++; if (obs_a !== exp_a || {ifa.DrawX, ifa.DrawY, ifa.frame_start, ifa.hs, ifa.frame_count} !== {20'd0, 2'b11, 8'd1}) begin
      errors++; $display("FAIL mid_restart_a got=%h exp=%h", obs_a, exp_a);
    end
    for (int k = 0; k < 6; k++) begin
      n = (k == 0) ? 0 : $urandom_range(0, 3 * S_TOT);
      repeat (n) begin
        step();
        checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL mid_run_s got=%h exp=%h", obs_s, exp_s); end
      end
      guard = 0;
      while (k == 0 && ifs.hs !== 1'b0 && guard < 100) begin step(); guard++; end
      rst_b = 1'b1; step(); rst_b = 1'b0;
      checks++; if (obs_s !== {10'd9, 10'd7, 6'b011110, 8'd0}) begin errors++; $display("FAIL mid_reset_s k=%0d got=%h", k, obs_s); end
      step();
      checks++; if ({ifs.DrawX, ifs.DrawY, ifs.blank, ifs.hs, ifs.frame_start, ifs.frame_count} !== {20'd0, 3'b111, 8'd1}) begin
        errors++; $display("FAIL mid_restart_s k=%0d got=%h", k, obs_s);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_a = ($urandom_range(0, 30) == 0);
      rst_b = ($urandom_range(0, 15) == 0);
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL rand_a i=%0d got=%h exp=%h", i, obs_a, exp_a); end
      checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL rand_s i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      checks++; if (obs_z !== exp_z) begin errors++; $display("FAIL rand_z i=%0d got=%h exp=%h", i, obs_z, exp_z); end
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_frame_wrap();
    int n, guard;
    rst_b = 1'b1; step(); rst_b = 1'b0; step();
    n = ifs.frame_start ? 1 : 0;
    guard = 0;
    while (n < 256 && guard < 256 * S_TOT + 10) begin
      step(); guard++;
      checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL wrap_model n=%0d got=%h exp=%h", n, obs_s, exp_s); end
      if (ifs.frame_start) begin
        n++;
        checks++; if (ifs.frame_count !== 8'(n % 256)) begin errors++; $display("FAIL wrap_fc n=%0d got=%0d exp=%0d", n, ifs.frame_count, n % 256); end
      end
    end
    checks++; if (n != 256) begin errors++; $display("FAIL wrap_count got=%0d exp=256", n); end
    checks++; if (ifs.frame_start !== 1'b1 || ifs.frame_count !== 8'd0) begin errors++; $display("FAIL wrap_final fs=%b fc=%0d exp fs=1 fc=0", ifs.frame_start, ifs.frame_count); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    test_random();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
